// File: rtl/penc_pkg.sv
// Shared definitions for the streaming priority encoder.
//   state_t    : controller states (IDLE waits for a vector, SCAN emits beats)
//   ORD_MSB    : scan order value selecting highest set bit first
//   ORD_LSB    : scan order value selecting lowest set bit first
//   clog2_min1 : ceil(log2(value)) clamped to at least 1, used for index widths
package penc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic ORD_MSB = 1'b0;
  localparam logic ORD_LSB = 1'b1;

  // Constant function: smallest r >= 1 with 2**r >= value.
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/penc_find_first.sv
// Combinational find-first over a request vector.
//   vector : request bits to search
//   ord    : ORD_MSB -> highest set bit, ORD_LSB -> lowest set bit
//   index  : position of the selected bit (0 when no bit is set)
//   any    : at least one bit is set
//   single : exactly one bit is set
// The search is a binary tree of 2-input slices. For MSB-first the leaves
// are fed bit-reversed so a single "lowest wins" tree serves both orders;
// the root index is mirrored back afterwards.
module penc_find_first
  import penc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] vector,
  input  logic             ord,
  output logic [IDX_W-1:0] index,
  output logic             any,
  output logic             single
);

  // Tree is padded to a power of two; pad leaves are constant zero.
  localparam int LEAVES = 1 << IDX_W;

  for (genvar gl = 0; gl <= IDX_W; gl++) begin : g_lvl
    localparam int N = LEAVES >> gl;
    logic [N-1:0]     any_v;
    logic [N-1:0]     single_v;
    logic [IDX_W-1:0] idx_v [N];

    if (gl == 0) begin : g_leaf
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
        if (gi < WIDTH) begin : g_real
          assign any_v[gi] = (ord == ORD_LSB) ? vector[gi] : vector[WIDTH-1-gi];
        end else begin : g_pad
          assign any_v[gi] = 1'b0;
        end
        assign single_v[gi] = any_v[gi];
        assign idx_v[gi]    = IDX_W'(gi);
      end
    end else begin : g_node
      for (genvar gi = 0; gi < N; gi++) begin : g_slice
        // Left child covers the lower leaf positions, so it wins when set.
        assign any_v[gi]    = g_lvl[gl-1].any_v[2*gi] | g_lvl[gl-1].any_v[2*gi+1];
        assign single_v[gi] = (g_lvl[gl-1].single_v[2*gi] & ~g_lvl[gl-1].any_v[2*gi+1]) |
                              (~g_lvl[gl-1].any_v[2*gi] & g_lvl[gl-1].single_v[2*gi+1]);
        assign idx_v[gi]    = g_lvl[gl-1].any_v[2*gi] ? g_lvl[gl-1].idx_v[2*gi]
                                                      : g_lvl[gl-1].idx_v[2*gi+1];
      end
    end
  end

  logic [IDX_W-1:0] root_idx;
  assign root_idx = g_lvl[IDX_W].idx_v[0];
  assign any      = g_lvl[IDX_W].any_v[0];
  assign single   = g_lvl[IDX_W].single_v[0];

  always_comb begin
    index = '0;
    if (any) begin
      index = (ord == ORD_LSB) ? root_idx : (IDX_W'(WIDTH - 1) - root_idx);
    end
  end

endmodule

// File: rtl/priority_enc_stream.sv
// Streaming priority encoder: accepts a WIDTH-bit request vector over a
// valid/ready handshake and emits the index of every set bit, one beat per
// cycle, MSB-first or LSB-first as chosen at accept time.
//   clk, rst       : clock, synchronous active-high reset
//   cfg_lsb_first  : scan order, sampled only when a vector is accepted
//   in_valid/in_ready/in_vector : request vector handshake
//   out_valid/out_ready         : beat handshake
//   out_index      : index of the current set bit
//   out_last       : final beat of this vector
//   out_empty      : accepted vector was zero (single beat, index 0, last 1)
//   busy           : a vector is being scanned
//   out_count      : popcount of the accepted vector (only with PENC_COUNT_EN)
// Build option: define PENC_COUNT_EN to add the out_count port.
module priority_enc_stream
  import penc_pkg::*;
#(
  parameter int  WIDTH = 16,
  localparam int IDX_W = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_lsb_first,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_empty,
  output logic             busy
`ifdef PENC_COUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;   // bits not yet handed off, incl. the one on the output
  logic             ord_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [IDX_W-1:0] out_index_reg;
  logic             out_last_reg;
  logic             out_empty_reg;

  logic             accept;
  logic             advance;
  logic             finish;
  logic [WIDTH-1:0] work_cleared;
  logic [WIDTH-1:0] ff_vector;
  logic             ff_ord;
  logic [IDX_W-1:0] ff_index;
  logic             ff_any;
  logic             ff_single;

  assign accept  = (state_reg == IDLE) && in_valid && in_ready_reg;
  assign advance = (state_reg == SCAN) && out_valid_reg && out_ready && !out_last_reg;
  assign finish  = (state_reg == SCAN) && out_valid_reg && out_ready && out_last_reg;

  // The search looks at what the work register will hold next cycle, so the
  // first beat lands one cycle after accept and later beats follow back to back.
  assign work_cleared = work_reg & ~(WIDTH'(1) << out_index_reg);
  assign ff_vector    = accept ? in_vector : work_cleared;
  assign ff_ord       = accept ? cfg_lsb_first : ord_reg;

  penc_find_first #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_find_first (
    .vector (ff_vector),
    .ord    (ff_ord),
    .index  (ff_index),
    .any    (ff_any),
    .single (ff_single)
  );

`ifdef PENC_COUNT_EN
  logic [IDX_W:0] in_popcount;
  logic [IDX_W:0] out_count_reg;

  always_comb begin
    in_popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_popcount = in_popcount + (IDX_W + 1)'(in_vector[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count_reg <= '0;
    end else if (accept) begin
      out_count_reg <= in_popcount;
    end
  end

  assign out_count = out_count_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      ord_reg       <= ORD_MSB;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_index_reg <= '0;
      out_last_reg  <= 1'b0;
      out_empty_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      in_ready_reg <= 1'b1;
      if (accept) begin
        state_reg     <= SCAN;
        work_reg      <= in_vector;
        ord_reg       <= cfg_lsb_first;
        in_ready_reg  <= 1'b0;
        out_valid_reg <= 1'b1;
        out_index_reg <= ff_index;
        // A zero vector still gets one beat, flagged empty and last.
        out_last_reg  <= ff_single | ~ff_any;
        out_empty_reg <= ~ff_any;
      end
    end else begin
      if (finish) begin
        state_reg     <= IDLE;
        work_reg      <= '0;
        in_ready_reg  <= 1'b1;
        out_valid_reg <= 1'b0;
        out_index_reg <= '0;
        out_last_reg  <= 1'b0;
        out_empty_reg <= 1'b0;
      end else if (advance) begin
        work_reg      <= work_cleared;
        out_index_reg <= ff_index;
        out_last_reg  <= ff_single;
        out_empty_reg <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_index = out_index_reg;
  assign out_last  = out_last_reg;
  assign out_empty = out_empty_reg;
  assign busy      = (state_reg == SCAN);

endmodule

// File: tb/tb_priority_enc_stream.sv
// Scoreboard bench for priority_enc_stream (WIDTH=16 main instance plus a
// WIDTH=5 instance for the narrow-width case).
module tb_priority_enc_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_lsb_first = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_vector = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_index;
  logic        out_last;
  logic        out_empty;
  logic        busy;
`ifdef PENC_COUNT_EN
  logic [4:0]  out_count;
`endif

  logic        cfg5 = 1'b0;
  logic        in_valid5 = 1'b0;
  logic        in_ready5;
  logic [4:0]  in_vector5 = '0;
  logic        out_valid5;
  logic        out_ready5 = 1'b1;
  logic [2:0]  out_index5;
  logic        out_last5;
  logic        out_empty5;
  logic        busy5;
`ifdef PENC_COUNT_EN
  logic [3:0]  out_count5;
`endif

  always #5 clk = ~clk;

  priority_enc_stream #(.WIDTH(16)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_lsb_first (cfg_lsb_first),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_vector     (in_vector),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .out_last      (out_last),
    .out_empty     (out_empty),
    .busy          (busy)
`ifdef PENC_COUNT_EN
    ,
    .out_count     (out_count)
`endif
  );

  priority_enc_stream #(.WIDTH(5)) u_dut5 (
    .clk           (clk),
    .rst           (rst),
    .cfg_lsb_first (cfg5),
    .in_valid      (in_valid5),
    .in_ready      (in_ready5),
    .in_vector     (in_vector5),
    .out_valid     (out_valid5),
    .out_ready     (out_ready5),
    .out_index     (out_index5),
    .out_last      (out_last5),
    .out_empty     (out_empty5),
    .busy          (busy5)
`ifdef PENC_COUNT_EN
    ,
    .out_count     (out_count5)
`endif
  );

  typedef struct {
    int idx;
    bit last;
    bit empty;
    int cnt;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0,...
  int    ready_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Consumer: out_ready changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = (ready_phase % 3 == 0);
          ready_phase++;
        end
      endcase
    end
  end

  // Monitor: pops and compares on every handshake, and checks that a stalled
  // beat does not move.
  bit         prev_stall = 0;
  logic [3:0] prev_idx;
  logic       prev_last;
  logic       prev_empty;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_index", 32'(out_index), 32'(prev_idx));
        check("stall_last", 32'(out_last), 32'(prev_last));
        check("stall_empty", 32'(out_empty), 32'(prev_empty));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got index %0d, expected no beat", out_index);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          $display("beat index=%0d last=%0d empty=%0d (exp %0d/%0d/%0d)",
                   out_index, out_last, out_empty, b.idx, b.last, b.empty);
          check("beat_index", 32'(out_index), 32'(b.idx));
          check("beat_last", 32'(out_last), 32'(b.last));
          check("beat_empty", 32'(out_empty), 32'(b.empty));
`ifdef PENC_COUNT_EN
          check("beat_count", 32'(out_count), 32'(b.cnt));
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_index;
      prev_last  = out_last;
      prev_empty = out_empty;
    end
  end

  // Reference model: walk the bit positions in the requested order and list
  // the set ones; a zero vector yields one empty beat.
  task automatic push_expected(input logic [15:0] vec, input bit lsb);
    int    k;
    int    seen;
    beat_t b;
    k = 0;
    for (int i = 0; i < 16; i++) if (vec[i]) k++;
    if (k == 0) begin
      b.idx = 0; b.last = 1; b.empty = 1; b.cnt = 0;
      exp_q.push_back(b);
    end else begin
      seen = 0;
      for (int n = 0; n < 16; n++) begin
        int i;
        i = lsb ? n : 15 - n;
        if (vec[i]) begin
          seen++;
          b.idx = i; b.last = (seen == k); b.empty = 0; b.cnt = k;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic wait_in_ready();
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 100 cycles");
    end
  endtask

  task automatic accept_vec(input logic [15:0] vec, input bit lsb);
    wait_in_ready();
    in_valid      = 1'b1;
    in_vector     = vec;
    cfg_lsb_first = lsb;
    $display("send vector=%h lsb_first=%0d mode=%0d", vec, lsb, ready_mode);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_vector = 16'($urandom);
    check("first_beat_latency", 32'(out_valid), 32'd1);
    check("in_ready_low_in_scan", 32'(in_ready), 32'd0);
    check("busy_in_scan", 32'(busy), 32'd1);
  endtask

  task automatic send(input logic [15:0] vec, input bit lsb, input int mode);
    int cyc;
    ready_mode  = mode;
    ready_phase = 0;
    push_expected(vec, lsb);
    accept_vec(vec, lsb);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      cfg_lsb_first = 1'($urandom_range(0, 1));   // must be ignored mid-scan
      @(posedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end else begin
      // We are one step past the last-beat handshake.
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [15:0] rv;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_empty", 32'(out_empty), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    send(16'h8421, 1'b0, 0);
    send(16'h8421, 1'b1, 0);
    send(16'h0000, 1'b0, 0);
    send(16'hFFFF, 1'b0, 2);
    send(16'h8000, 1'b1, 1);
    send(16'h0001, 1'b0, 1);

    // Randomized vectors, orders and backpressure
    for (int t = 0; t < 24; t++) begin
      rv = 16'($urandom);
      if (t % 3 == 0) rv = rv & 16'($urandom);
      if (t % 7 == 0) rv = 16'(1 << $urandom_range(0, 15));
      send(rv, 1'($urandom_range(0, 1)), 1);
    end

    // Reset during a burst: discard the remaining beats
    ready_mode = 0;
    push_expected(16'h00F0, 1'b0);
    accept_vec(16'h00F0, 1'b0);
    cyc = 0;
    while (exp_q.size() > 2 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("mid_rst_beats_left", 32'(exp_q.size()), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(16'h0001, 1'b0, 0);

    // Narrow instance: 5'b10010 MSB-first gives 4 then 1
    cyc = 0;
    while (!in_ready5 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("w5_in_ready", 32'(in_ready5), 32'd1);
    in_valid5  = 1'b1;
    in_vector5 = 5'b10010;
    cfg5       = 1'b0;
    $display("send w5 vector=%b lsb_first=0", in_vector5);
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
    check("w5_beat0_valid", 32'(out_valid5), 32'd1);
    check("w5_beat0_index", 32'(out_index5), 32'd4);
    check("w5_beat0_last", 32'(out_last5), 32'd0);
`ifdef PENC_COUNT_EN
    check("w5_beat0_count", 32'(out_count5), 32'd2);
`endif
    @(posedge clk);
    #1;
    check("w5_beat1_valid", 32'(out_valid5), 32'd1);
    check("w5_beat1_index", 32'(out_index5), 32'd1);
    check("w5_beat1_last", 32'(out_last5), 32'd1);
`ifdef PENC_COUNT_EN
    check("w5_beat1_count", 32'(out_count5), 32'd2);
`endif
    @(posedge clk);
    #1;
    check("w5_done_valid", 32'(out_valid5), 32'd0);
    check("w5_done_in_ready", 32'(in_ready5), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
